// File: rtl/udp_rx_port_demux_pkg.sv
// Shared constants and FSM state type for the UDP receive demux.
package udp_rx_pkg;
  localparam int UDP_HDR_LEN = 8;
  localparam int OFF_SRC_HI  = 0;
  localparam int OFF_SRC_LO  = 1;
  localparam int OFF_DST_HI  = 2;
  localparam int OFF_DST_LO  = 3;
  localparam int OFF_LEN_HI  = 4;
  localparam int OFF_LEN_LO  = 5;
  localparam int OFF_CSUM_LO = 7;

  typedef enum logic [2:0] {IDLE, HDR, PAYLD, SKIP, ABORT} state_t;
endpackage

// File: rtl/udp_rx_port_demux_if.sv
// AXI-Stream payload bus out of the UDP demux.
interface udp_rx_port_demux_if #(parameter int DATA_W = 32, parameter int DEST_W = 2);
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic                tvalid;
  logic                tlast;
  logic [DEST_W-1:0]   tdest;
  logic                tuser;
  logic                tready;

  modport master (output tdata, tkeep, tvalid, tlast, tdest, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tdest, tuser, output tready);
endinterface

// File: rtl/udp_rx_port_demux_byte_packer.sv
// Packs bytes into DATA_W-bit beats; beat_done pulses the cycle after a beat closes.
module byte_packer #(parameter int DATA_W = 32) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                byte_vld,
  input  logic [7:0]          byte_in,
  input  logic                last,
  input  logic                flush,
  output logic [DATA_W-1:0]   beat_data,
  output logic [DATA_W/8-1:0] beat_keep,
  output logic                beat_done
);
  localparam int KEEP_W = DATA_W/8;
  localparam int CNT_W  = (KEEP_W > 1) ? $clog2(KEEP_W) : 1;

  logic [DATA_W-1:0] acc, acc_nxt;
  logic [KEEP_W-1:0] keep_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              emit;

  always_comb begin
    acc_nxt  = acc;
    keep_nxt = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      if (byte_vld && cnt == CNT_W'(i)) acc_nxt[8*i +: 8] = byte_in;
      keep_nxt[i] = (CNT_W'(i) < cnt) || (byte_vld && CNT_W'(i) == cnt);
    end
    // flush without a byte closes whatever is held, possibly an empty beat
    emit = (byte_vld && (last || cnt == CNT_W'(KEEP_W-1))) || flush;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc       <= '0;
      cnt       <= '0;
      beat_data <= '0;
      beat_keep <= '0;
      beat_done <= 1'b0;
    end else begin
      beat_done <= emit;
      if (emit) begin
        beat_data <= acc_nxt;
        beat_keep <= keep_nxt;
        acc       <= '0;
        cnt       <= '0;
      end else if (byte_vld) begin
        acc <= acc_nxt;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/udp_rx_port_demux.sv
// UDP header parse, destination-port match and payload packing onto AXI-Stream.
module udp_rx_port_demux
  import udp_rx_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int N_PORTS = 4
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [7:0]             data_in,
  input  logic                   data_valid,
  input  logic                   ip_header_done,
  input  logic [16*N_PORTS-1:0]  port_table,
  input  logic [N_PORTS-1:0]     port_en,
  udp_rx_port_demux_if.master    m_axis,
  output logic [15:0]            rx_src_port,
  output logic                   pkt_accepted,
  output logic                   pkt_dropped
);
  localparam int KEEP_W = DATA_W/8;
  localparam int DEST_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  state_t            state, state_nxt;
  logic [15:0]       cnt, cnt_nxt;
  logic [15:0]       src_q, dst_q, len_q, pay_len;
  logic [DEST_W-1:0] dest_q, hit_idx;
  logic              hit, hdr_ok, acc_p, drop_p;
  logic              pk_vld, pk_last, pk_flush, pk_clear;
  logic              beat_last_q, beat_err_q;
  logic [DATA_W-1:0] beat_data;
  logic [KEEP_W-1:0] beat_keep;
  logic              beat_done, out_busy, load_beat, load_term, overflow;

  byte_packer #(.DATA_W(DATA_W)) u_pack (
    .clk(aclk), .rst(areset), .clear(pk_clear), .byte_vld(pk_vld), .byte_in(data_in),
    .last(pk_last), .flush(pk_flush),
    .beat_data(beat_data), .beat_keep(beat_keep), .beat_done(beat_done)
  );

  // descending scan so the lowest enabled index wins
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = N_PORTS-1; i >= 0; i--)
      if (port_en[i] && port_table[16*i +: 16] == dst_q) begin
        hit     = 1'b1;
        hit_idx = DEST_W'(i);
      end
  end

  assign out_busy  = m_axis.tvalid && !m_axis.tready;
  assign load_beat = beat_done && !out_busy;
  assign overflow  = beat_done && out_busy;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pk_vld    = 1'b0;
    pk_last   = 1'b0;
    pk_flush  = 1'b0;
    pk_clear  = 1'b0;
    hdr_ok    = 1'b0;
    load_term = 1'b0;
    acc_p     = load_beat && beat_last_q && !beat_err_q;
    drop_p    = load_beat && beat_last_q && beat_err_q;
    case (state)
      IDLE: if (ip_header_done) begin
        state_nxt = HDR;
        cnt_nxt   = '0;
      end
      HDR: if (!data_valid) begin
        state_nxt = IDLE;
        drop_p    = 1'b1;
      end else begin
        cnt_nxt = cnt + 16'd1;
        if (cnt == 16'(OFF_CSUM_LO)) begin
          if (!hit || len_q < 16'(UDP_HDR_LEN)) begin
            state_nxt = SKIP;
            drop_p    = 1'b1;
          end else begin
            hdr_ok  = 1'b1;
            cnt_nxt = '0;
            if (len_q == 16'(UDP_HDR_LEN)) begin
              state_nxt = SKIP;
              acc_p     = 1'b1;
            end else state_nxt = PAYLD;
          end
        end
      end
      PAYLD: if (overflow) begin
        state_nxt = ABORT;
        pk_clear  = 1'b1;
      end else if (!data_valid) begin
        pk_flush  = 1'b1;
        state_nxt = SKIP;
      end else begin
        pk_vld  = 1'b1;
        pk_last = (cnt + 16'd1 == pay_len);
        cnt_nxt = cnt + 16'd1;
        if (pk_last) state_nxt = SKIP;
      end
      // the final beat lands one cycle after the last byte, so overflow can still hit here
      SKIP: if (overflow) begin
        state_nxt = ABORT;
        pk_clear  = 1'b1;
      end else if (!data_valid) state_nxt = IDLE;
      ABORT: if (!out_busy) begin
        load_term = 1'b1;
        drop_p    = 1'b1;
        state_nxt = SKIP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state        <= IDLE;
      cnt          <= '0;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      pay_len      <= '0;
      dest_q       <= '0;
      beat_last_q  <= 1'b0;
      beat_err_q   <= 1'b0;
      rx_src_port  <= '0;
      pkt_accepted <= 1'b0;
      pkt_dropped  <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      pkt_accepted <= acc_p;
      pkt_dropped  <= drop_p;
      beat_last_q  <= pk_flush || (pk_vld && pk_last);
      beat_err_q   <= pk_flush;
      if (state == HDR && data_valid)
        case (cnt[2:0])
          3'(OFF_SRC_HI): src_q[15:8] <= data_in;
          3'(OFF_SRC_LO): src_q[7:0]  <= data_in;
          3'(OFF_DST_HI): dst_q[15:8] <= data_in;
          3'(OFF_DST_LO): dst_q[7:0]  <= data_in;
          3'(OFF_LEN_HI): len_q[15:8] <= data_in;
          3'(OFF_LEN_LO): len_q[7:0]  <= data_in;
          default: ;
        endcase
      if (hdr_ok) begin
        rx_src_port <= src_q;
        dest_q      <= hit_idx;
        pay_len     <= len_q - 16'(UDP_HDR_LEN);
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      m_axis.tvalid <= 1'b0;
      m_axis.tdata  <= '0;
      m_axis.tkeep  <= '0;
      m_axis.tlast  <= 1'b0;
      m_axis.tuser  <= 1'b0;
      m_axis.tdest  <= '0;
    end else if (load_beat) begin
      m_axis.tvalid <= 1'b1;
      m_axis.tdata  <= beat_data;
      m_axis.tkeep  <= beat_keep;
      m_axis.tlast  <= beat_last_q;
      m_axis.tuser  <= beat_err_q;
      m_axis.tdest  <= dest_q;
    end else if (load_term) begin
      m_axis.tvalid <= 1'b1;
      m_axis.tdata  <= '0;
      m_axis.tkeep  <= '0;
      m_axis.tlast  <= 1'b1;
      m_axis.tuser  <= 1'b1;
      m_axis.tdest  <= dest_q;
    end else if (m_axis.tready) m_axis.tvalid <= 1'b0;
  end
endmodule

// File: tb/tb_udp_rx_port_demux.sv
// Bench for udp_rx_port_demux: vector table, overflow/reset sequences, random frames vs datagram model.
module tb_udp_rx_port_demux;
  localparam int DATA_W = 32, N_PORTS = 4, KEEP_W = 4, DEST_W = 2;

  typedef struct packed {
    logic [31:0] data; logic [3:0] keep; logic last; logic [1:0] dest; logic user;
  } beat_t;

  typedef struct {
    logic [63:0] pt; logic [3:0] pe; logic [15:0] dst, len;
    int hdr_n, pay_n, exp_beats, exp_acc, exp_drop, exp_dest;
  } vec_t;

  logic aclk = 0, areset;
  logic [7:0] data_in;
  logic data_valid, ip_header_done;
  logic [16*N_PORTS-1:0] port_table;
  logic [N_PORTS-1:0] port_en;
  logic [15:0] rx_src_port;
  logic pkt_accepted, pkt_dropped;

  udp_rx_port_demux_if #(.DATA_W(DATA_W), .DEST_W(DEST_W)) axis ();

  udp_rx_port_demux #(.DATA_W(DATA_W), .N_PORTS(N_PORTS)) dut (
    .aclk(aclk), .areset(areset), .data_in(data_in), .data_valid(data_valid),
    .ip_header_done(ip_header_done), .port_table(port_table), .port_en(port_en),
    .m_axis(axis), .rx_src_port(rx_src_port), .pkt_accepted(pkt_accepted), .pkt_dropped(pkt_dropped)
  );

  always #5 aclk = ~aclk;

  int n_cmp = 0, n_bad = 0;
  int acc_cnt = 0, drop_cnt = 0;
  beat_t obs_q[$];
  beat_t exp_beats[$];
  int exp_acc, exp_drop;
  logic [15:0] exp_src = 16'd0;
  logic [7:0] pay_bytes [64];
  vec_t vecs [11];

  localparam logic [63:0] CFG_A = {16'd53, 16'd81, 16'd80, 16'd5000};
  localparam logic [63:0] CFG_B = {16'd80, 16'd80, 16'd80, 16'd80};

  always @(negedge aclk) begin
    if (!areset) begin
      if (axis.tvalid && axis.tready)
        obs_q.push_back('{axis.tdata, axis.tkeep, axis.tlast, axis.tdest, axis.tuser});
      if (pkt_accepted) acc_cnt++;
      if (pkt_dropped) drop_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (actual=timeout required=finish)");
    $fatal(1);
  end

  task automatic step();
    @(posedge aclk); #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] pk(input beat_t b);
    logic [31:0] m = '0;
    for (int i = 0; i < KEEP_W; i++) m[8*i +: 8] = {8{b.keep[i]}};
    return {24'd0, b.data & m, b.keep, b.last, b.dest, b.user};
  endfunction

  function automatic vec_t mk(input logic [63:0] pt, input logic [3:0] pe, input logic [15:0] dst, len,
                              input int hn, pn, eb, ea, ed, edst);
    vec_t v;
    v.pt = pt; v.pe = pe; v.dst = dst; v.len = len; v.hdr_n = hn; v.pay_n = pn;
    v.exp_beats = eb; v.exp_acc = ea; v.exp_drop = ed; v.exp_dest = edst;
    return v;
  endfunction

  // Datagram-level expectation: which entry matches, how many payload bytes arrive, how they chunk.
  task automatic model(input logic [63:0] pt, input logic [3:0] pe, input logic [15:0] src, dst, len,
                       input int hdr_n, pay_n);
    int hit, pl, got, nb, n;
    bit trunc;
    beat_t b;
    exp_beats.delete(); exp_acc = 0; exp_drop = 0;
    if (hdr_n < 8) begin exp_drop = 1; return; end
    hit = -1;
    for (int i = 0; i < N_PORTS; i++) if (hit < 0 && pe[i] && pt[16*i +: 16] == dst) hit = i;
    if (hit < 0 || len < 8) begin exp_drop = 1; return; end
    exp_src = src;
    pl = int'(len) - 8;
    if (pl == 0) begin exp_acc = 1; return; end
    got = (pay_n < pl) ? pay_n : pl;
    trunc = (got < pl);
    nb = trunc ? got / KEEP_W + 1 : (got + KEEP_W - 1) / KEEP_W;
    for (int k = 0; k < nb; k++) begin
      n = got - k*KEEP_W; if (n > KEEP_W) n = KEEP_W;
      b = '0;
      for (int j = 0; j < n; j++) begin b.data[8*j +: 8] = pay_bytes[k*KEEP_W + j]; b.keep[j] = 1'b1; end
      b.last = (k == nb-1); b.user = b.last && trunc; b.dest = 2'(hit);
      exp_beats.push_back(b);
    end
    if (trunc) exp_drop = 1; else exp_acc = 1;
  endtask

  task automatic drive_hdr(input logic [15:0] src, dst, len, input int hdr_n);
    logic [7:0] h [8];
    h[0] = src[15:8]; h[1] = src[7:0]; h[2] = dst[15:8]; h[3] = dst[7:0];
    h[4] = len[15:8]; h[5] = len[7:0]; h[6] = 8'hAB;      h[7] = 8'hCD;
    data_in = 8'h45; data_valid = 1'b1; ip_header_done = 1'b1; step();
    ip_header_done = 1'b0;
    for (int i = 0; i < hdr_n; i++) begin data_in = h[i]; step(); end
  endtask

  task automatic drive_frame(input logic [15:0] src, dst, len, input int hdr_n, pay_n);
    drive_hdr(src, dst, len, hdr_n);
    if (hdr_n == 8) for (int i = 0; i < pay_n; i++) begin data_in = pay_bytes[i]; step(); end
    data_valid = 1'b0; data_in = 8'h00;
    repeat (8) step();
  endtask

  task automatic check_frame(input string tag, input int base, a0, d0);
    int nobs = obs_q.size() - base;
    chk({tag, " beat count"}, 64'(nobs), 64'(exp_beats.size()));
    for (int i = 0; i < nobs && i < exp_beats.size(); i++)
      chk($sformatf("%s beat%0d", tag, i), pk(obs_q[base+i]), pk(exp_beats[i]));
    chk({tag, " accepted"}, 64'(acc_cnt - a0), 64'(exp_acc));
    chk({tag, " dropped"}, 64'(drop_cnt - d0), 64'(exp_drop));
    chk({tag, " src port"}, 64'(rx_src_port), 64'(exp_src));
  endtask

  task automatic run_frame(input string tag, input logic [63:0] pt, input logic [3:0] pe,
                           input logic [15:0] src, dst, len, input int hdr_n, pay_n,
                           output int nb, na, nd, ldest);
    int base, a0, d0;
    port_table = pt; port_en = pe;
    model(pt, pe, src, dst, len, hdr_n, pay_n);
    base = obs_q.size(); a0 = acc_cnt; d0 = drop_cnt;
    drive_frame(src, dst, len, hdr_n, pay_n);
    check_frame(tag, base, a0, d0);
    nb = obs_q.size() - base; na = acc_cnt - a0; nd = drop_cnt - d0;
    ldest = (nb > 0) ? int'(obs_q[obs_q.size()-1].dest) : -1;
  endtask

  initial begin
    int nb, na, nd, ld, base, a0, d0;
    logic [15:0] pool [4];
    string tag;
    pool[0] = 16'd80; pool[1] = 16'd81; pool[2] = 16'd5000; pool[3] = 16'd53;
    for (int i = 0; i < 64; i++) pay_bytes[i] = 8'(i + 1);

    //             cfg    en     dst       len  hdr pay beats acc drop dest
    vecs[0]  = mk(CFG_A, 4'h1, 16'd5000, 16'd20, 8, 12, 3, 1, 0, 0);
    vecs[1]  = mk(CFG_A, 4'h1, 16'd5000, 16'd15, 8, 15, 2, 1, 0, 0);
    vecs[2]  = mk(CFG_B, 4'hC, 16'd80,   16'd12, 8,  4, 1, 1, 0, 2);
    vecs[3]  = mk(CFG_B, 4'hC, 16'd81,   16'd12, 8,  4, 0, 0, 1, -1);
    vecs[4]  = mk(CFG_A, 4'h1, 16'd5000, 16'd8,  8,  4, 0, 1, 0, -1);
    vecs[5]  = mk(CFG_A, 4'h1, 16'd5000, 16'd4,  8,  4, 0, 0, 1, -1);
    vecs[6]  = mk(CFG_A, 4'h1, 16'd5000, 16'd20, 8,  5, 2, 0, 1, 0);
    vecs[7]  = mk(CFG_A, 4'h1, 16'd5000, 16'd20, 5,  0, 0, 0, 1, -1);
    vecs[8]  = mk(CFG_A, 4'h1, 16'd5000, 16'd20, 8,  8, 3, 0, 1, 0);
    vecs[9]  = mk(CFG_A, 4'h1, 16'd5000, 16'd20, 8,  0, 1, 0, 1, 0);
    vecs[10] = mk(CFG_A, 4'h1, 16'd80,   16'd20, 8, 12, 0, 0, 1, -1);

    areset = 1'b1; data_in = '0; data_valid = 1'b0; ip_header_done = 1'b0;
    port_table = '0; port_en = '0; axis.tready = 1'b1;
    repeat (3) step();
    chk("reset tvalid", 64'(axis.tvalid), 64'd0);
    chk("reset tkeep/tlast/tuser", {axis.tkeep, axis.tlast, axis.tuser}, 64'd0);
    chk("reset pulses", {pkt_accepted, pkt_dropped}, 64'd0);
    chk("reset src port", 64'(rx_src_port), 64'd0);
    areset = 1'b0; step();

    for (int v = 0; v < 11; v++) begin
      tag = $sformatf("vec%0d", v);
      base = obs_q.size();
      run_frame(tag, vecs[v].pt, vecs[v].pe, 16'(1000 + v), vecs[v].dst, vecs[v].len,
                vecs[v].hdr_n, vecs[v].pay_n, nb, na, nd, ld);
      chk({tag, " table beats"}, 64'(nb), 64'(vecs[v].exp_beats));
      chk({tag, " table acc/drop"}, {32'(na), 32'(nd)}, {32'(vecs[v].exp_acc), 32'(vecs[v].exp_drop)});
      if (vecs[v].exp_beats > 0) chk({tag, " table tdest"}, 64'(ld), 64'(vecs[v].exp_dest));
      if (v == 0 && nb > 2) begin
        chk("vec0 beat0 data", 64'(obs_q[base].data), 64'h04030201);
        chk("vec0 beat2 data/last", {obs_q[base+2].data, 3'b0, obs_q[base+2].last}, {32'h0C0B0A09, 4'h1});
      end
      if (v == 6 && nb > 1)
        chk("vec6 tail keep/last/user", {obs_q[base+1].keep, obs_q[base+1].last, obs_q[base+1].user}, {4'h1, 2'b11});
    end

    // overflow: hold tready low across a 16-byte payload
    port_table = CFG_A; port_en = 4'h1;
    base = obs_q.size(); a0 = acc_cnt; d0 = drop_cnt;
    axis.tready = 1'b0;
    drive_frame(16'd7, 16'd5000, 16'd24, 8, 16);
    chk("ovf held beat", {axis.tvalid, axis.tlast, axis.tkeep, axis.tdata}, {1'b1, 1'b0, 4'hF, 32'h04030201});
    axis.tready = 1'b1;
    repeat (4) step();
    exp_beats.delete();
    exp_beats.push_back('{32'h04030201, 4'hF, 1'b0, 2'd0, 1'b0});
    exp_beats.push_back('{32'h0, 4'h0, 1'b1, 2'd0, 1'b1});
    exp_acc = 0; exp_drop = 1; exp_src = 16'd7;
    check_frame("ovf", base, a0, d0);

    // reset in the middle of a payload with a beat held
    base = obs_q.size();
    axis.tready = 1'b0;
    drive_hdr(16'd9, 16'd5000, 16'd20, 8);
    for (int i = 0; i < 6; i++) begin data_in = pay_bytes[i]; step(); end
    chk("midrst tvalid before", 64'(axis.tvalid), 64'd1);
    areset = 1'b1; step();
    areset = 1'b0; data_valid = 1'b0;
    chk("midrst tvalid after", 64'(axis.tvalid), 64'd0);
    chk("midrst src port", 64'(rx_src_port), 64'd0);
    exp_src = 16'd0;
    axis.tready = 1'b1;
    repeat (4) step();
    chk("midrst no stale beats", 64'(obs_q.size() - base), 64'd0);
    run_frame("post-reset", vecs[0].pt, vecs[0].pe, 16'd1234, vecs[0].dst, vecs[0].len,
              8, 12, nb, na, nd, ld);

    // random datagrams, always-ready sink
    for (int r = 0; r < 40; r++) begin
      logic [63:0] pt;
      logic [15:0] len;
      int hn, pn;
      for (int i = 0; i < 4; i++) pt[16*i +: 16] = pool[$urandom_range(0, 3)];
      len = 16'($urandom_range(0, 34));
      hn = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : 8;
      pn = (len > 8) ? int'($urandom_range(0, int'(len) - 8 + 6)) : int'($urandom_range(0, 5));
      for (int i = 0; i < 64; i++) pay_bytes[i] = 8'($urandom);
      run_frame($sformatf("rnd%0d", r), pt, 4'($urandom), 16'($urandom), pool[$urandom_range(0, 3)],
                len, hn, pn, nb, na, nd, ld);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
